mul_pipe_ctrl: RTL and testbench

Sequencing controller for a fixed-latency pipelined multiplier datapath in the execute stage. Tracks per-stage valid, destination tag and speculation state for every in-flight multiply. Applies branch-miss kills and branch-success spectag clears to in-flight ops. Arbitrates the shared writeback slot through a request/grant handshake and stalls the whole pipe when the grant is withheld.

---
 rtl/mul_pipe_ctrl_pkg.sv | 19 +
 rtl/mul_pipe_ctrl_stage.sv | 71 +++++++
 rtl/mul_pipe_ctrl.sv | 83 ++++++++
 tb/tb_mul_pipe_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pipe_ctrl_pkg.sv
// Shared execute-unit constants and the speculation kill predicate.
// The widths here fix the operand and tag sizes for every exec unit that imports this package.
package mul_pipe_ctrl_pkg;

  localparam int SPECTAG_LEN = 5;
  localparam int RRF_SEL     = 6;
  localparam int DATA_LEN    = 32;

  // An op dies when a mispredict resolves on a branch it depends on.
  function automatic logic spec_kill(
    input logic                   prmiss,
    input logic                   sb,
    input logic [SPECTAG_LEN-1:0] st,
    input logic [SPECTAG_LEN-1:0] spectagfix
  );
    return prmiss & sb & ((st & spectagfix) != '0);
  endfunction

endpackage

// File: rtl/mul_pipe_ctrl_stage.sv
// One multiplier pipeline stage of control state: {v, tag, dval, sb, st}.
// Loads from upstream when enabled, otherwise holds; kill and spectag-fix apply every edge.
module mul_stage_tag
  import mul_pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en_i,
  input  logic                   v_i,
  input  logic [RRF_SEL-1:0]     tag_i,
  input  logic                   dval_i,
  input  logic                   sb_i,
  input  logic [SPECTAG_LEN-1:0] st_i,
  input  logic                   prmiss_i,
  input  logic                   prsuccess_i,
  input  logic [SPECTAG_LEN-1:0] spectagfix_i,
  output logic                   v_o,
  output logic [RRF_SEL-1:0]     tag_o,
  output logic                   dval_o,
  output logic                   sb_o,
  output logic [SPECTAG_LEN-1:0] st_o
);

  logic                   v_q, v_d;
  logic [RRF_SEL-1:0]     tag_q, tag_d;
  logic                   dval_q, dval_d;
  logic                   sb_q, sb_d;
  logic [SPECTAG_LEN-1:0] st_q, st_d;

  logic                   cand_v, cand_sb;
  logic [SPECTAG_LEN-1:0] cand_st;

  always_comb begin
    cand_v  = en_i ? v_i  : v_q;
    cand_sb = en_i ? sb_i : sb_q;
    cand_st = en_i ? st_i : st_q;
    tag_d   = en_i ? tag_i  : tag_q;
    dval_d  = en_i ? dval_i : dval_q;
    // Kill is judged on the pre-fix tag; a mispredict masks any same-cycle success.
    v_d  = cand_v & ~spec_kill(prmiss_i, cand_sb, cand_st, spectagfix_i);
    st_d = cand_st;
    sb_d = cand_sb;
    if (prsuccess_i && !prmiss_i) begin
      st_d = cand_st & ~spectagfix_i;
      sb_d = cand_sb & (st_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= 1'b0;
      tag_q  <= '0;
      dval_q <= 1'b0;
      sb_q   <= 1'b0;
      st_q   <= '0;
    end else begin
      v_q    <= v_d;
      tag_q  <= tag_d;
      dval_q <= dval_d;
      sb_q   <= sb_d;
      st_q   <= st_d;
    end
  end

  assign v_o    = v_q;
  assign tag_o  = tag_q;
  assign dval_o = dval_q;
  assign sb_o   = sb_q;
  assign st_o   = st_q;

endmodule

// File: rtl/mul_pipe_ctrl.sv
// Sequencing controller for the fixed-latency pipelined multiplier: per-stage tracking,
// speculative kill/fix, and a writeback request/grant that stalls the whole pipe.
module mul_pipe_ctrl
  import mul_pipe_ctrl_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue,
  output logic                   issue_ready,
  input  logic [RRF_SEL-1:0]     rrftag,
  input  logic                   dstval,
  input  logic                   specbit,
  input  logic [SPECTAG_LEN-1:0] spectag,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] spectagfix,
  output logic                   pipe_en,
  output logic                   wb_valid,
  input  logic                   wb_grant,
  output logic [RRF_SEL-1:0]     wb_rrftag,
  output logic                   rrf_we,
  output logic                   rob_we,
  output logic                   empty
);

  logic [LATENCY-1:0]     v, dval, sb, live;
  logic [RRF_SEL-1:0]     tag [LATENCY];
  logic [SPECTAG_LEN-1:0] st  [LATENCY];

  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
      logic                   in_v, in_dval, in_sb;
      logic [RRF_SEL-1:0]     in_tag;
      logic [SPECTAG_LEN-1:0] in_st;

      if (gi == 0) begin : g_head
        assign in_v    = issue;
        assign in_tag  = rrftag;
        assign in_dval = dstval;
        assign in_sb   = specbit;
        assign in_st   = spectag;
      end else begin : g_body
        assign in_v    = v[gi-1];
        assign in_tag  = tag[gi-1];
        assign in_dval = dval[gi-1];
        assign in_sb   = sb[gi-1];
        assign in_st   = st[gi-1];
      end

      mul_stage_tag u_stage (
        .clk          (clk),
        .reset        (reset),
        .en_i         (pipe_en),
        .v_i          (in_v),
        .tag_i        (in_tag),
        .dval_i       (in_dval),
        .sb_i         (in_sb),
        .st_i         (in_st),
        .prmiss_i     (prmiss),
        .prsuccess_i  (prsuccess),
        .spectagfix_i (spectagfix),
        .v_o          (v[gi]),
        .tag_o        (tag[gi]),
        .dval_o       (dval[gi]),
        .sb_o         (sb[gi]),
        .st_o         (st[gi])
      );

      assign live[gi] = v[gi] & ~spec_kill(prmiss, sb[gi], st[gi], spectagfix);
    end
  endgenerate

  assign wb_valid    = live[LATENCY-1];
  assign wb_rrftag   = tag[LATENCY-1];
  assign pipe_en     = ~wb_valid | wb_grant;
  assign issue_ready = pipe_en;
  assign rob_we      = wb_valid & wb_grant;
  assign rrf_we      = rob_we & dval[LATENCY-1];
  assign empty       = (live == '0);

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Directed bench for mul_pipe_ctrl (LATENCY=3): inputs change 1ns after posedge,
// outputs are sampled at the following negedge.
module tb_mul_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset, issue, issue_ready, dstval, specbit;
  logic [5:0] rrftag, wb_rrftag;
  logic [4:0] spectag, spectagfix;
  logic       prmiss, prsuccess, pipe_en, wb_valid, wb_grant, rrf_we, rob_we, empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_pipe_ctrl #(.LATENCY(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue       (issue),
    .issue_ready (issue_ready),
    .rrftag      (rrftag),
    .dstval      (dstval),
    .specbit     (specbit),
    .spectag     (spectag),
    .prmiss      (prmiss),
    .prsuccess   (prsuccess),
    .spectagfix  (spectagfix),
    .pipe_en     (pipe_en),
    .wb_valid    (wb_valid),
    .wb_grant    (wb_grant),
    .wb_rrftag   (wb_rrftag),
    .rrf_we      (rrf_we),
    .rob_we      (rob_we),
    .empty       (empty)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic put(input logic [5:0] t, input logic d, input logic s, input logic [4:0] st);
    issue = 1'b1; rrftag = t; dstval = d; specbit = s; spectag = st;
  endtask

  task automatic idle();
    issue = 1'b0; rrftag = '0; dstval = 1'b0; specbit = 1'b0; spectag = '0;
  endtask

  initial begin
    reset = 1'b1; wb_grant = 1'b0; prmiss = 1'b0; prsuccess = 1'b0; spectagfix = '0;
    idle();
    tick(); tick();
    reset = 1'b0;
    sample();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_rob_we", rob_we, 0);
    chk("rst_rrf_we", rrf_we, 0);
    chk("rst_pipe_en", pipe_en, 1);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_empty", empty, 1);

    // Back-to-back issues, tags 1,2,3; only tags 1 and 3 write a register.
    wb_grant = 1'b1;
    put(6'd1, 1'b1, 1'b0, 5'd0); tick();
    put(6'd2, 1'b0, 1'b0, 5'd0); tick();
    put(6'd3, 1'b1, 1'b0, 5'd0); sample();
    chk("b2b_early_wb", wb_valid, 0);
    tick(); idle(); sample();
    chk("b2b1_wb_valid", wb_valid, 1);
    chk("b2b1_tag", wb_rrftag, 1);
    chk("b2b1_rob_we", rob_we, 1);
    chk("b2b1_rrf_we", rrf_we, 1);
    tick(); sample();
    chk("b2b2_wb_valid", wb_valid, 1);
    chk("b2b2_tag", wb_rrftag, 2);
    chk("b2b2_rob_we", rob_we, 1);
    chk("b2b2_rrf_we", rrf_we, 0);
    tick(); sample();
    chk("b2b3_tag", wb_rrftag, 3);
    chk("b2b3_rrf_we", rrf_we, 1);
    tick(); sample();
    chk("b2b_done_empty", empty, 1);
    chk("b2b_done_wb", wb_valid, 0);

    // Grant withheld for two cycles while a new issue is held at the input.
    put(6'd9, 1'b1, 1'b0, 5'd0); tick();
    idle(); tick(); tick();
    wb_grant = 1'b0; put(6'd10, 1'b1, 1'b0, 5'd0); sample();
    chk("stall1_wb_valid", wb_valid, 1);
    chk("stall1_pipe_en", pipe_en, 0);
    chk("stall1_issue_ready", issue_ready, 0);
    chk("stall1_rob_we", rob_we, 0);
    chk("stall1_tag", wb_rrftag, 9);
    tick(); sample();
    chk("stall2_pipe_en", pipe_en, 0);
    chk("stall2_tag", wb_rrftag, 9);
    chk("stall2_rob_we", rob_we, 0);
    tick(); wb_grant = 1'b1; sample();
    chk("grant_rob_we", rob_we, 1);
    chk("grant_rrf_we", rrf_we, 1);
    chk("grant_tag", wb_rrftag, 9);
    chk("grant_pipe_en", pipe_en, 1);
    tick(); idle(); sample();
    chk("resume_wb_valid", wb_valid, 0);
    chk("resume_empty", empty, 0);
    tick(); tick(); sample();
    chk("resume_tag10_wb", wb_valid, 1);
    chk("resume_tag10", wb_rrftag, 10);
    tick(); sample();
    chk("resume_done_empty", empty, 1);

    // Mispredict kills the dependent op only.
    put(6'd4, 1'b1, 1'b1, 5'b00010); tick();
    put(6'd5, 1'b1, 1'b1, 5'b00100); tick();
    idle(); prmiss = 1'b1; spectagfix = 5'b00010; sample();
    chk("miss_empty", empty, 0);
    tick(); prmiss = 1'b0; sample();
    chk("miss_killed_wb", wb_valid, 0);
    tick(); sample();
    chk("miss_survivor_wb", wb_valid, 1);
    chk("miss_survivor_tag", wb_rrftag, 5);
    tick(); sample();
    chk("miss_done_empty", empty, 1);

    // Mispredict on an op sitting in the last stage masks its request at once.
    put(6'd6, 1'b1, 1'b1, 5'b01000); tick();
    idle(); tick(); tick();
    prmiss = 1'b1; spectagfix = 5'b01000; sample();
    chk("lastkill_wb_valid", wb_valid, 0);
    chk("lastkill_rob_we", rob_we, 0);
    chk("lastkill_empty", empty, 1);
    tick(); prmiss = 1'b0; sample();
    chk("lastkill_after_empty", empty, 1);

    // Success clears the speculation bit; a later mispredict spares the op.
    put(6'd7, 1'b1, 1'b1, 5'b00010); tick();
    idle(); prsuccess = 1'b1; spectagfix = 5'b00010; tick();
    prsuccess = 1'b0; prmiss = 1'b1; sample();
    chk("fix_empty", empty, 0);
    tick(); prmiss = 1'b0; sample();
    chk("fix_wb_valid", wb_valid, 1);
    chk("fix_tag", wb_rrftag, 7);
    tick(); sample();

    // Issue in the same cycle as a matching mispredict is dropped.
    prmiss = 1'b1; spectagfix = 5'b00010; put(6'd8, 1'b1, 1'b1, 5'b00010); sample();
    chk("issmiss_empty_now", empty, 1);
    tick(); idle(); prmiss = 1'b0; sample();
    chk("issmiss_empty_next", empty, 1);
    tick(); tick(); sample();
    chk("issmiss_wb_valid", wb_valid, 0);

    // Simultaneous mispredict and success: mispredict wins.
    put(6'd14, 1'b1, 1'b1, 5'b00010); tick();
    idle(); prmiss = 1'b1; prsuccess = 1'b1; spectagfix = 5'b00010; sample();
    chk("both_empty", empty, 1);
    tick(); prmiss = 1'b0; prsuccess = 1'b0; tick(); sample();
    chk("both_wb_valid", wb_valid, 0);
    chk("both_empty_later", empty, 1);

    // Reset with three ops in flight discards them all.
    wb_grant = 1'b0;
    put(6'd11, 1'b1, 1'b0, 5'd0); tick();
    put(6'd12, 1'b1, 1'b0, 5'd0); tick();
    put(6'd13, 1'b1, 1'b0, 5'd0); tick();
    idle(); sample();
    chk("prerst_wb_valid", wb_valid, 1);
    chk("prerst_rob_we", rob_we, 0);
    reset = 1'b1; tick(); reset = 1'b0; wb_grant = 1'b1; sample();
    chk("midrst_empty", empty, 1);
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_issue_ready", issue_ready, 1);
    chk("midrst_rob_we", rob_we, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); sample();
      chk("midrst_no_rob_we", rob_we, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
